// File: rtl/pipe_pkg.sv
// Shared types, widths and sizing helpers for the elastic pipeline stage buffer.
package pipe_pkg;

  localparam int unsigned STATS_W = 32;

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  // MEM->WB payload bundle; the stage packs it into the opaque data word.
  typedef struct packed {
    logic [1:0]  mem_to_reg;
    logic        reg_write;
    logic [31:0] alu_result;
    logic [31:0] read_data;
    logic [4:0]  write_reg;
    logic [31:0] pc;
  } mem_wb_t;

endpackage

// File: rtl/pipe_buf_mem.sv
// DEPTH x DATA_W register array: one write port, asynchronous read, cleared on reset.
module pipe_buf_mem
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 72,
  parameter int unsigned DEPTH  = 2,
  localparam int unsigned AW    = ptr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic valid/ready pipeline stage with flush, occupancy and optional stats.
// Stats counters are built only when PIPE_STAGE_BUF_STATS_EN is defined.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 72,
  parameter int unsigned DEPTH  = 2,
  localparam int unsigned CNT_W = cnt_w(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  input  logic               flush,
  output logic [CNT_W-1:0]   count,
  output logic [STATS_W-1:0] stall_cnt,
  output logic [CNT_W-1:0]   hwm
);

  localparam int unsigned PW            = ptr_w(DEPTH);
  localparam logic [PW-1:0]    LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              push_c, pop_c, wr_en_c;
  logic [DATA_W-1:0] rd_data;

  pipe_buf_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en_c),
    .waddr (wr_ptr_q),
    .wdata (in_data),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  // Control state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state: flush beats any push/pop; ready/valid are precomputed so both stay registered.
  always_comb begin
    push_c      = in_valid && in_ready_q;
    pop_c       = out_valid_q && out_ready;
    wr_en_c     = 1'b0;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    if (flush) begin
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
      count_d     = '0;
      in_ready_d  = 1'b1;
      out_valid_d = 1'b0;
    end else begin
      wr_en_c = push_c;
      if (push_c) begin
        wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
      end
      if (pop_c) begin
        rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
      end
      if (push_c && !pop_c) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop_c && !push_c) begin
        count_d = count_q - CNT_W'(1);
      end
      in_ready_d  = (count_d != FULL_CNT);
      out_valid_d = (count_d != '0);
    end
  end

  assign count     = count_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_valid_q ? rd_data : '0;

`ifdef PIPE_STAGE_BUF_STATS_EN
  logic [STATS_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0]   hwm_q, hwm_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      hwm_q   <= '0;
    end else begin
      stall_q <= stall_d;
      hwm_q   <= hwm_d;
    end
  end

  // Saturating stall counter; high-water mark survives flush.
  always_comb begin
    stall_d = stall_q;
    hwm_d   = hwm_q;
    if (!flush && out_valid_q && !out_ready && (stall_q != '1)) begin
      stall_d = stall_q + STATS_W'(1);
    end
    if (count_d > hwm_q) begin
      hwm_d = count_d;
    end
  end

  assign stall_cnt = stall_q;
  assign hwm       = hwm_q;
`else
  assign stall_cnt = '0;
  assign hwm       = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: a DEPTH=2 payload-bundle instance and a DEPTH=3 byte instance.
module tb_pipe_stage_buf;
  import pipe_pkg::*;

  localparam int unsigned W2 = $bits(mem_wb_t);
  localparam int unsigned W3 = 8;
`ifdef PIPE_STAGE_BUF_STATS_EN
  localparam int unsigned STATS = 1;
`else
  localparam int unsigned STATS = 0;
`endif

  logic clk = 1'b0;
  logic rst;

  logic          iv2, ir2, ov2, or2, fl2;
  logic [W2-1:0] id2, od2;
  logic [1:0]    cnt2, hw2;
  logic [31:0]   st2;

  logic          iv3, ir3, ov3, or3, fl3;
  logic [W3-1:0] id3, od3;
  logic [1:0]    cnt3, hw3;
  logic [31:0]   st3;

  int checks = 0;
  int errors = 0;

  logic [W3-1:0] q3[$];
  bit            pend3;

  logic          hold2, hold3;
  logic [W2-1:0] hd2;
  logic [W3-1:0] hd3;

  always #5 clk = ~clk;

  pipe_stage_buf #(.DATA_W(W2), .DEPTH(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .in_data(id2),
    .out_valid(ov2), .out_ready(or2), .out_data(od2), .flush(fl2),
    .count(cnt2), .stall_cnt(st2), .hwm(hw2)
  );

  pipe_stage_buf #(.DATA_W(W3), .DEPTH(3)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(iv3), .in_ready(ir3), .in_data(id3),
    .out_valid(ov3), .out_ready(or3), .out_data(od3), .flush(fl3),
    .count(cnt3), .stall_cnt(st3), .hwm(hw3)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Upstream must hold in_data while a beat waits on in_ready.
  always @(posedge clk) begin
    if (hold2) check("stable2", id2, hd2);
    if (hold3) check("stable3", id3, hd3);
    hold2 = iv2 && !ir2 && !rst && !fl2;
    hold3 = iv3 && !ir3 && !rst && !fl3;
    hd2   = id2;
    hd3   = id3;
  end

  // Random push/pop on the DEPTH=3 instance against a reference queue.
  task automatic rand_steps(input int n);
    bit m_push, m_pop;
    for (int i = 0; i < n; i++) begin
      if (!pend3) begin
        iv3 = 1'($urandom_range(0, 1));
        id3 = W3'($urandom);
      end
      or3    = 1'($urandom_range(0, 1));
      m_push = iv3 && (q3.size() != 3);
      m_pop  = (q3.size() != 0) && or3;
      pend3  = iv3 && !m_push;
      tick();
      if (m_pop) void'(q3.pop_front());
      if (m_push) q3.push_back(id3);
      check("rand_cnt", cnt3, q3.size());
      check("rand_ovalid", ov3, q3.size() != 0);
      check("rand_iready", ir3, q3.size() != 3);
      check("rand_odata", od3, (q3.size() != 0) ? q3[0] : '0);
    end
  endtask

  initial begin
    hold2 = 0; hold3 = 0; hd2 = '0; hd3 = '0; pend3 = 0;
    rst = 1;
    iv2 = 0; id2 = '0; or2 = 0; fl2 = 0;
    iv3 = 0; id3 = '0; or3 = 0; fl3 = 0;

    // Reset then idle
    tick(); tick();
    check("rst_ovalid2", ov2, 1'b0);
    check("rst_odata2", od2, '0);
    check("rst_iready2", ir2, 1'b1);
    check("rst_cnt2", cnt2, 2'd0);
    check("rst_stall2", st2, 32'd0);
    check("rst_hwm2", hw2, 2'd0);
    check("rst_iready3", ir3, 1'b1);
    check("rst_cnt3", cnt3, 2'd0);
    rst = 0;
    tick();
    check("idle_ovalid2", ov2, 1'b0);
    check("idle_cnt2", cnt2, 2'd0);

    // Streaming 1..10 with no bubbles
    or2 = 1;
    for (int i = 1; i <= 10; i++) begin
      iv2 = 1; id2 = W2'(i);
      tick();
      check("stream_data", od2, W2'(i));
      check("stream_ovalid", ov2, 1'b1);
      check("stream_cnt", cnt2, 2'd1);
    end
    iv2 = 0;
    tick();
    check("stream_drain_ovalid", ov2, 1'b0);
    check("stream_drain_odata", od2, '0);
    check("stream_stall", st2, 32'd0);
    check("stream_hwm", hw2, 2'(STATS));

    // Back-pressure fill on DEPTH=2
    or2 = 0; iv2 = 1; id2 = W2'(8'hA);
    tick();
    check("bp_cnt1", cnt2, 2'd1);
    id2 = W2'(8'hB);
    tick();
    check("bp_cnt2", cnt2, 2'd2);
    check("bp_iready", ir2, 1'b0);
    check("bp_head", od2, W2'(8'hA));
    id2 = W2'(8'hC);
    tick(); tick();
    check("bp_hold_cnt", cnt2, 2'd2);
    check("bp_hold_head", od2, W2'(8'hA));
    or2 = 1;
    tick();
    check("bp_out_b", od2, W2'(8'hB));
    check("bp_cnt_after_pop", cnt2, 2'd1);
    check("bp_iready_after_pop", ir2, 1'b1);
    tick();
    check("bp_out_c", od2, W2'(8'hC));
    check("bp_cnt_c", cnt2, 2'd1);
    iv2 = 0;
    tick();
    check("bp_empty", ov2, 1'b0);
    check("bp_stall", st2, 32'(3 * STATS));
    check("bp_hwm", hw2, 2'(2 * STATS));

    // Push+pop while full on DEPTH=3
    or3 = 0; iv3 = 1;
    for (int i = 1; i <= 3; i++) begin
      id3 = W3'(i);
      tick();
    end
    check("full3_cnt", cnt3, 2'd3);
    check("full3_iready", ir3, 1'b0);
    id3 = 8'h4; or3 = 1;
    tick();
    check("full3_pop_cnt", cnt3, 2'd2);
    check("full3_pop_iready", ir3, 1'b1);
    check("full3_pop_head", od3, 8'h2);
    tick();
    check("full3_pp_cnt", cnt3, 2'd2);
    check("full3_pp_head", od3, 8'h3);
    iv3 = 0;
    tick();
    check("full3_out4", od3, 8'h4);
    tick();
    check("full3_empty", ov3, 1'b0);
    check("full3_stall", st3, 32'(2 * STATS));
    check("full3_hwm", hw3, 2'(3 * STATS));

    // Flush with a concurrent push
    or3 = 0; iv3 = 1; id3 = 8'h11;
    tick();
    id3 = 8'h22;
    tick();
    check("fl_pre_cnt", cnt3, 2'd2);
    fl3 = 1; id3 = 8'h55;
    tick();
    check("fl_cnt", cnt3, 2'd0);
    check("fl_ovalid", ov3, 1'b0);
    check("fl_odata", od3, 8'h00);
    check("fl_iready", ir3, 1'b1);
    check("fl_stall", st3, 32'(3 * STATS));
    check("fl_hwm", hw3, 2'(3 * STATS));
    fl3 = 0; id3 = 8'h66; or3 = 1;
    tick();
    check("fl_next_head", od3, 8'h66);
    check("fl_next_cnt", cnt3, 2'd1);
    iv3 = 0;
    tick();
    check("fl_next_empty", ov3, 1'b0);

    // Random traffic with pointer wrap, then reset mid-sequence
    or3 = 0;
    rand_steps(20);
    rand_steps(6);
    rst = 1;
    tick();
    q3.delete(); pend3 = 0;
    check("mid_rst_cnt", cnt3, 2'd0);
    check("mid_rst_ovalid", ov3, 1'b0);
    check("mid_rst_odata", od3, 8'h00);
    check("mid_rst_iready", ir3, 1'b1);
    check("mid_rst_stall", st3, 32'd0);
    check("mid_rst_hwm", hw3, 2'd0);
    rst = 0; iv3 = 0;
    rand_steps(14);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised elastic pipeline stage register. Successor to the fixed-field stage registers between pipeline stages (e.g. MEM->WB).
- Carries an opaque DATA_W-bit payload bundle (control + data fields packed by the instantiating stage) through a DEPTH-entry buffer.
- Adds a valid/ready handshake, back-pressure, flush and occupancy reporting.
- Lets the core stall one stage without freezing the whole pipeline.

Parameters:
- DATA_W, 72, payload width in bits (>=1).
- DEPTH, 2, buffer entries (>=2; 2 gives full throughput with registered in_ready).
- CNT_W, $clog2(DEPTH+1), occupancy counter width (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  buffer can accept (registered, no combinational path from out_ready).
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts head.
- out_data  out  DATA_W  head payload.
- flush  in  1  discard all entries (branch/exception squash).
- count  out  CNT_W  current occupancy 0..DEPTH.
- stall_cnt  out  32  stats: cycles with out_valid && !out_ready.
- hwm  out  CNT_W  stats: occupancy high-water mark.

Behaviour:
- Reset (rst=1 at posedge): count=0, rd/wr pointers=0, all storage=0, out_valid=0, out_data=0, in_ready=1, stall_cnt=0, hwm=0. Reset mid-transfer drops all entries; no beat is emitted in that cycle.
- Push = in_valid && in_ready. Pop = out_valid && out_ready. Both evaluated on the same edge.
- Storage: circular buffer. wr_ptr advances on push, rd_ptr on pop. Pointers wrap from DEPTH-1 to 0, which must be correct for non-power-of-2 DEPTH.
- out_valid = (count != 0). out_data = entry[rd_ptr], driven from registers. out_data = 0 when empty.
- in_ready = (count != DEPTH), registered as next-state. With DEPTH>=2 a simultaneous push+pop keeps one beat per cycle.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged.
  - neither: unchanged.
- Latency: a beat pushed at edge N is visible on out_data after edge N (1-cycle latency) when the buffer was empty. No bypass path.
- Full: in_ready=0. in_valid is ignored and in_data is not written. The upstream must hold in_valid/in_data (protocol rule, asserted in bench).
- Empty: out_valid=0. out_ready is ignored.
- Flush (sync, priority below rst, above push/pop): count=0, pointers=0, out_valid=0 next cycle. A push in the same cycle is discarded. in_ready=1 next cycle. Storage contents need not be cleared, but out_data reads 0 while empty.
- Ordering: strict FIFO. No duplication or loss except on flush/rst.
- Upstream stability: once in_valid=1 && in_ready=0, in_data must not change until the push. Bench checks this; RTL does not.

Optional Feature:
- Macro: PIPE_STAGE_BUF_STATS_EN.
- Defined:
  - stall_cnt increments (saturating at 32'hFFFF_FFFF) each cycle out_valid && !out_ready, excluding reset and flush cycles.
  - hwm holds the max count seen since rst. Flush does not clear hwm.
- Undefined: stall_cnt and hwm tied to 0, no counter flops synthesised. Ports remain for interface stability.

Decomposition:
- Package pipe_pkg:
  - function cnt_w(depth) returning $clog2(depth+1).
  - ptr_w(depth) returning $clog2(depth) (min 1).
  - localparam STATS_W=32.
  - typedef for the MEM->WB payload bundle (memtoReg[1:0], regWrite, ALUResult[31:0], readData[31:0], writeReg[4:0], PC[31:0]), so DATA_W is derived as $bits of the bundle at instantiation.
- Sub-module pipe_buf_mem: DEPTH x DATA_W register array with write port (we, waddr, wdata), async read (raddr), synchronous clear on rst. Pointer/count/handshake control stays in pipe_stage_buf.

Test Plan:
- Reset then idle: rst high 2 cycles -> out_valid=0, out_data=0, in_ready=1, count=0, stall_cnt=0.
- Streaming: in_valid=1, out_ready=1, in_data=1..10 on consecutive cycles -> out_data 1..10 on consecutive cycles starting 1 cycle later, count stays 1, no bubbles.
- Back-pressure fill: out_ready=0, push 0xA,0xB -> count=2, in_ready=0. A third in_valid with 0xC is held. Raise out_ready -> outputs 0xA,0xB,0xC in order, with stats on stall_cnt equal to the stalled cycles and hwm=2.
- Simultaneous push+pop at full (DEPTH=3, count=3): in_valid=1 with in_ready=0, out_ready=1 -> pop only that cycle, count=2, in_ready=1 next cycle.
- Flush with concurrent push: count=2, flush=1, in_valid=1, in_data=0x55 -> next cycle count=0, out_valid=0, 0x55 never emitted. Next push 0x66 emerges first.
- Wrap-around, DEPTH=3: 20 random push/pop patterns against a reference queue model -> identical order, count never >3, pointers wrap 2->0 correctly. Repeat with rst asserted mid-sequence -> all state zeroed.
